// File: rtl/frq_div_prog.sv
// Programmable 50%-duty clock divider / tone generator.
// Ratio reloads only at half-period boundaries; stopping always finishes the high phase.
module frq_div_prog #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_HALF = 4,
  parameter int unsigned CYC_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] half_in,
  input  logic             load,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             active,
  output logic [CYC_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             active_q, active_d;
  logic             load_ack_q, load_ack_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic             boundary;

  assign boundary = (cnt_q == half_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    cyc_cnt_d  = cyc_cnt_q;
    load_ack_d = load;

    unique case (state_q)
      StIdle: begin
        clk_out_d = 1'b0;
        cnt_d     = '0;
        if (pend_v_q) begin
          half_d   = pend_q;
          pend_v_d = 1'b0;
        end
        if (en) begin
          state_d = StRun;
        end
      end
      StRun, StStop: begin
        if (!en && !clk_out_q) begin
          // Low phase can be abandoned immediately without a short pulse.
          state_d   = StIdle;
          cnt_d     = '0;
          clk_out_d = 1'b0;
        end else if (boundary) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
          tick_d    = 1'b1;
          if (clk_out_q) begin
            cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
          end
          if (pend_v_q) begin
            half_d   = pend_q;
            pend_v_d = 1'b0;
          end
          // Reaching here with en low implies clk_out was high and has just fallen.
          state_d = en ? StRun : StIdle;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = en ? StRun : StStop;
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase

    // A load in the same cycle as a consume stays pending for the next boundary.
    if (load) begin
      pend_d   = half_in;
      pend_v_d = 1'b1;
    end

    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      half_q     <= CNT_W'(DEF_HALF);
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      active_q   <= 1'b0;
      load_ack_q <= 1'b0;
      cyc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      active_q   <= active_d;
      load_ack_q <= load_ack_d;
      cyc_cnt_q  <= cyc_cnt_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign active   = active_q;
  assign load_ack = load_ack_q;
  assign cyc_cnt  = cyc_cnt_q;

endmodule

// File: tb/tb_frq_div_prog.sv
// Randomized bench for frq_div_prog against a phase-countdown reference model.
module tb_frq_div_prog;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DEF_HALF = 4;
  localparam int unsigned CYC_W    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] half_in;
  logic             load;
  logic             load_ack;
  logic             clk_out;
  logic             tick;
  logic             active;
  logic [CYC_W-1:0] cyc_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a running flag plus cycles remaining in the current phase.
  int m_half, m_pend, m_left, m_cyc;
  bit m_pv, m_on, m_out, m_tick, m_ack;

  always #5 clk = ~clk;

  frq_div_prog #(
    .CNT_W   (CNT_W),
    .DEF_HALF(DEF_HALF),
    .CYC_W   (CYC_W)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .half_in (half_in),
    .load    (load),
    .load_ack(load_ack),
    .clk_out (clk_out),
    .tick    (tick),
    .active  (active),
    .cyc_cnt (cyc_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) begin
        $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_half = DEF_HALF;
      m_pv   = 1'b0;
      m_on   = 1'b0;
      m_out  = 1'b0;
      m_tick = 1'b0;
      m_ack  = 1'b0;
      m_cyc  = 0;
      m_left = 0;
      return;
    end
    m_ack  = load;
    m_tick = 1'b0;
    if (!m_on) begin
      m_out = 1'b0;
      if (m_pv) begin
        m_half = m_pend;
        m_pv   = 1'b0;
      end
      if (en) begin
        m_on   = 1'b1;
        m_left = m_half + 1;
      end
    end else if (!en && !m_out) begin
      m_on = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_out  = !m_out;
        m_tick = 1'b1;
        if (!m_out) m_cyc = (m_cyc + 1) % (1 << CYC_W);
        if (m_pv) begin
          m_half = m_pend;
          m_pv   = 1'b0;
        end
        m_left = m_half + 1;
        if (!en) m_on = 1'b0;
      end
    end
    if (load) begin
      m_pend = int'(half_in);
      m_pv   = 1'b1;
    end
  endtask

  // Inputs are already stable; advance one edge, update the model, compare off-edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("clk_out", 32'(clk_out), 32'(m_out));
    check("tick", 32'(tick), 32'(m_tick));
    check("active", 32'(active), 32'(m_on));
    check("load_ack", 32'(load_ack), 32'(m_ack));
    check("cyc_cnt", 32'(cyc_cnt), 32'(m_cyc));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    half_in = '0;
    m_pend  = 0;
    run(2);

    // Default ratio free-running
    rst = 1'b0;
    en  = 1'b1;
    run(43);

    // Load a short ratio mid-phase, then drop en
    half_in = 16'd1;
    load    = 1'b1;
    step();
    load    = 1'b0;
    half_in = 16'd9;
    run(20);
    en = 1'b0;
    run(12);

    // Divide-by-two with cyc_cnt wrap
    half_in = 16'd0;
    load    = 1'b1;
    step();
    load = 1'b0;
    step();
    en = 1'b1;
    run(600);

    // Back-to-back loads, last wins
    half_in = 16'd3;
    load    = 1'b1;
    step();
    half_in = 16'd2;
    step();
    load = 1'b0;
    run(30);

    // Reset mid-run with a pending value
    half_in = 16'd7;
    load    = 1'b1;
    step();
    load = 1'b0;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    run(25);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) half_in = CNT_W'($urandom_range(0, 40));
      else half_in = CNT_W'($urandom_range(0, 6));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst  = 1'b0;
    load = 1'b0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
